// File: rtl/if_id_fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register: PC, stall/redirect handling, decode field split.
// Optional performance counters are enabled with `define IF_ID_PERF_EN.
module if_id_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] PC_STEP   = 32'h0000_0001,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [3:0]  id_opcode,
    output logic [5:0]  id_rd,
    output logic [5:0]  id_rs,
    output logic [5:0]  id_rt,
    output logic [5:0]  id_imm6
`ifdef IF_ID_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_bubble_cnt
`endif
);

    localparam int unsigned XLEN = 32;

    logic [XLEN-1:0] pc_q,    pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] idpc_q,  idpc_d;
    logic            valid_q, valid_d;
    logic            load_c;

    // Next-state selection: redirect beats stall beats normal fetch.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        idpc_d  = idpc_q;
        valid_d = valid_q;
        load_c  = 1'b0;
        if (redirect) begin
            pc_d    = redirect_pc;
            instr_d = NOP_INSTR;
            idpc_d  = pc_q;
            valid_d = 1'b0;
        end else if (!stall) begin
            pc_d    = XLEN'(pc_q + PC_STEP);
            instr_d = imem_rdata;
            idpc_d  = pc_q;
            valid_d = 1'b1;
            load_c  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            idpc_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            idpc_q  <= idpc_d;
            valid_q <= valid_d;
        end
    end

    assign imem_addr = pc_q;
    assign id_valid  = valid_q;
    assign id_instr  = instr_q;
    assign id_pc     = idpc_q;

    // Decode fields; immediate forms reuse the rt bits.
    assign id_opcode = instr_q[31:28];
    assign id_rd     = instr_q[27:22];
    assign id_rs     = instr_q[21:16];
    assign id_rt     = instr_q[15:10];
    assign id_imm6   = instr_q[15:10];

`ifdef IF_ID_PERF_EN
    logic [XLEN-1:0] fetch_cnt_q,  fetch_cnt_d;
    logic [XLEN-1:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (load_c) begin
            fetch_cnt_d = XLEN'(fetch_cnt_q + XLEN'(1));
        end else begin
            bubble_cnt_d = XLEN'(bubble_cnt_q + XLEN'(1));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign perf_fetch_cnt  = fetch_cnt_q;
    assign perf_bubble_cnt = bubble_cnt_q;
`else
    logic unused_load;
    assign unused_load = load_c;
`endif

endmodule

// File: doc/if_id_fetch_stage.md
Name: if_id_fetch_stage

Overview:
- Instruction fetch stage plus IF/ID pipeline register for the 32-bit datapath.
- Holds the PC, drives the instruction-memory address, and latches the fetched word with its PC.
- Splits the latched word into decode fields. id_imm6 feeds the 6-bit sign extender directly; the register fields feed the register file.
- Supports stall (hold) and redirect (branch/jump with squash).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 1, PC increment per fetch (word-addressed instruction memory)
NOP_INSTR, 32'h0000_0000, word inserted into IF/ID on squash or reset

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
stall  in  1  hold PC and IF/ID contents
redirect  in  1  taken branch/jump; load redirect_pc and squash
redirect_pc  in  32  redirect target
imem_addr  out  32  instruction memory address, equal to the PC register
imem_rdata  in  32  instruction word, combinational from imem_addr
id_valid  out  1  IF/ID holds a real instruction
id_instr  out  32  latched instruction
id_pc  out  32  PC of id_instr
id_opcode  out  4  id_instr[31:28]
id_rd  out  6  id_instr[27:22]
id_rs  out  6  id_instr[21:16]
id_rt  out  6  id_instr[15:10]
id_imm6  out  6  id_instr[15:10], to sign extender (same bits as id_rt; immediate forms reuse the rt field)

Behaviour:
- Reset is asynchronous and active-high; one clock, clk.
- Reset values, applied immediately when reset asserts, including mid-operation:
  - PC = RESET_PC, so imem_addr = RESET_PC.
  - id_valid = 0, id_instr = NOP_INSTR, id_pc = 0.
  - Field outputs reflect NOP_INSTR.
- imem_addr is the PC register output, with no combinational path from any input.
- Decode field outputs are pure slices of the id_instr register, valid in the same cycle.
- Priority at each rising edge (reset deasserted): redirect > stall > normal.
- Normal (stall=0, redirect=0):
  - id_instr <= imem_rdata; id_pc <= PC; id_valid <= 1.
  - PC <= PC + PC_STEP, computed modulo 2^32, so 32'hFFFF_FFFF + 1 wraps to 0.
- Stall (stall=1, redirect=0): PC, id_instr, id_pc and id_valid all hold.
- Redirect (redirect=1, stall is don't-care):
  - PC <= redirect_pc.
  - id_instr <= NOP_INSTR; id_valid <= 0; id_pc <= PC (the squashed slot's PC, for debug only).
  - The first instruction at the target appears in IF/ID one edge later, so a taken redirect costs one bubble.
- Back-to-back redirects: each edge loads the newest redirect_pc; id_valid stays 0 throughout.
- Latency:
  - Instruction at address A appears on id_instr one edge after imem_addr = A.
  - The first valid instruction after reset deassert appears after the first edge, with id_pc = RESET_PC.
- Reset deassertion need not be synchronised here; the top level deasserts it synchronously.
- No X propagation: if imem_rdata is X while stalled, the held outputs must not change.

Optional Feature:
- Macro: IF_ID_PERF_EN.
- Defined:
  - Adds output perf_fetch_cnt (32 bits): count of edges that loaded a valid instruction (normal case only).
  - Adds output perf_bubble_cnt (32 bits): count of edges with stall=1 or redirect=1.
  - Both counters reset to 0 and wrap modulo 2^32.
- Undefined: neither port exists and no counter logic is synthesised. Core behaviour is identical either way.

Test Plan:
- Reset/sequence: RESET_PC=0; imem returns 32'h1000_0000+addr; release reset for 4 edges -> id_pc 0,1,2,3; id_instr 32'h1000_0000..32'h1000_0003; id_valid=1 from the first edge.
- Decode slicing: imem_rdata=32'hA5C3_7E40 latched -> id_opcode=4'hA, id_rd=6'h17, id_rs=6'h03, id_rt=id_imm6=6'h1F.
- Stall: stall=1 for 3 edges at PC=5 -> imem_addr stays 5; id_pc=4 and id_instr unchanged; release -> id_pc=5 next edge.
- Redirect over stall: stall=1 and redirect=1 with redirect_pc=32'h40 -> next edge id_valid=0, id_instr=NOP_INSTR, imem_addr=32'h40; following edge id_pc=32'h40, id_valid=1.
- Wrap and async reset: redirect to 32'hFFFF_FFFF, run 2 edges -> id_pc 32'hFFFF_FFFF then 0. Assert reset mid-cycle between edges -> id_valid=0 and imem_addr=RESET_PC before the next edge.
- IF_ID_PERF_EN defined: 10 normal, 3 stall and 2 redirect edges -> perf_fetch_cnt=10, perf_bubble_cnt=5; reset -> both 0.
